// File: rtl/mul9_pp_sequencer_pkg.sv
// Shared constants, column-geometry helpers and FSM encoding for the 9x9
// partial-product sequencer.
package mul9_pkg;

    localparam int WIDTH = 9;
    localparam int NCOL  = 2*WIDTH - 1;
    localparam int PW    = 2*WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_SETTLE,
        ST_DONE
    } state_t;

    // Number of a[i]&b[j] terms that land in column k of a w x w multiply.
    function automatic int col_height(input int k, input int w);
        int ncol;
        ncol = 2*w - 1;
        return (k + 1 < ncol - k) ? k + 1 : ncol - k;
    endfunction

    function automatic int col_base_i(input int k, input int w);
        return (k - w + 1 > 0) ? k - w + 1 : 0;
    endfunction

endpackage

// File: rtl/mul9_pp_sequencer_pp_column_mux.sv
// For shift index i_t, selects the partial-product bit each column shifts in,
// so that a column's last h(k) shifts carry exactly its own terms.
module pp_column_mux
    import mul9_pkg::*;
#(
    parameter int W = WIDTH
)(
    input  logic [W-1:0]         i_a,
    input  logic [W-1:0]         i_b,
    input  logic [$clog2(W)-1:0] i_t,
    output logic [2*W-2:0]       o_col
);
    localparam int TW = $clog2(W);

    for (genvar k = 0; k < 2*W-1; k++) begin : g_col
        localparam int            H    = col_height(k, W);
        localparam int            I0   = col_base_i(k, W);
        localparam logic [TW-1:0] LEAD = TW'(W - H);

        logic [W-1:0]  w_terms;
        logic [TW-1:0] w_idx;

        for (genvar n = 0; n < W; n++) begin : g_term
            if (n < H) begin : g_used
                assign w_terms[n] = i_a[I0+n] & i_b[k-I0-n];
            end else begin : g_pad
                assign w_terms[n] = 1'b0;
            end
        end

        assign w_idx    = i_t - LEAD;
        assign o_col[k] = (i_t >= LEAD) ? w_terms[w_idx] : 1'b0;
    end

endmodule

// File: rtl/mul9_pp_sequencer.sv
// Sequences one 9x9 unsigned multiply through the external partial-product
// shift register and compressor, then checks and returns the product.
//
// state     | meaning
// ST_IDLE   | ready for an operand pair
// ST_SHIFT  | feeding partial-product bits, t = 0..WIDTH-1
// ST_SETTLE | waiting SETTLE cycles for the compressor
// ST_DONE   | result held until res_ready
module mul9_pp_sequencer
    import mul9_pkg::*;
#(
    parameter int SETTLE = 1,
    parameter int ERR_W  = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [NCOL-1:0]  sr_src,
    input  logic [PW-1:0]    sr_dst,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [PW-1:0]    res_product,
    output logic             res_mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic             busy
);
    localparam int            TW          = $clog2(WIDTH);
    localparam int            SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [TW-1:0] T_LAST      = TW'(WIDTH - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

    state_t           r_state, w_state_nxt;
    logic [TW-1:0]    r_t, w_t_nxt;
    logic [SW-1:0]    r_settle;
    logic [WIDTH-1:0] r_a, r_b, w_a_sel, w_b_sel;
    logic [NCOL-1:0]  r_sr_src, w_col;
    logic [PW-1:0]    r_res_product, w_expect;
    logic             r_res_mismatch;
    logic [ERR_W-1:0] r_err_count;
    logic             w_accept, w_capture, w_mismatch;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_t == T_LAST) w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_settle == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_t_nxt = r_t;
        if (w_accept)
            w_t_nxt = '0;
        else if (r_state == ST_SHIFT && r_t != T_LAST)
            w_t_nxt = r_t + TW'(1);
    end

    // The mux looks one cycle ahead (next operands, next t) so that the
    // registered sr_src shows bit t exactly while the FSM sits at t.
    assign w_a_sel = w_accept ? in_a : r_a;
    assign w_b_sel = w_accept ? in_b : r_b;

    pp_column_mux #(
        .W (WIDTH)
    ) u_pp_column_mux (
        .i_a   (w_a_sel),
        .i_b   (w_b_sel),
        .i_t   (w_t_nxt),
        .o_col (w_col)
    );

    assign w_expect   = PW'(r_a) * PW'(r_b);
    assign w_mismatch = (sr_dst != w_expect);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_t            <= '0;
            r_settle       <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_sr_src       <= '0;
            r_res_product  <= '0;
            r_res_mismatch <= 1'b0;
            r_err_count    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_t      <= w_t_nxt;
            r_sr_src <= (w_state_nxt == ST_SHIFT) ? w_col : '0;
            if (w_accept) begin
                r_a <= in_a;
                r_b <= in_b;
            end
            if (r_state == ST_SHIFT && r_t == T_LAST)
                r_settle <= SETTLE_LOAD;
            else if (r_state == ST_SETTLE && r_settle != '0)
                r_settle <= r_settle - SW'(1);
            if (w_capture) begin
                r_res_product  <= sr_dst;
                r_res_mismatch <= w_mismatch;
                if (w_mismatch && r_err_count != '1)
                    r_err_count <= r_err_count + ERR_W'(1);
            end
        end
    end

    assign in_ready     = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign res_valid    = (r_state == ST_DONE);
    assign sr_src       = r_sr_src;
    assign res_product  = r_res_product;
    assign res_mismatch = r_res_mismatch;
    assign err_count    = r_err_count;

endmodule
